// File: rtl/serial_bit_pkg.sv
// Shared types and constants for the serial bit transmitter.
// The PARITY state is only used when SERIAL_BIT_TX_PARITY_EN is defined.
package serial_bit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_bit_tick.sv
// Per-bit cycle counter: o_tick marks the last cycle of a line bit.
import serial_bit_pkg::*;

module serial_bit_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int TW = cnt_w(CLKS_PER_BIT);
    localparam logic [TW-1:0] TERM = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_cnt;

    assign o_tick = (r_cnt == TERM);

    // Restarting on the terminal count lets consecutive DATA bits reuse the counter.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + TW'(1);
    end

endmodule

// File: rtl/serial_bit_tx.sv
// Framed parallel-to-serial transmitter: start, WIDTH data bits LSB first, stop.
// Define SERIAL_BIT_TX_PARITY_EN to insert an even-parity bit before stop.
import serial_bit_pkg::*;

module serial_bit_tx #(
    parameter int WIDTH        = 10,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_line,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BW = cnt_w(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [BW-1:0]    r_bitcnt, w_bitcnt_nxt;
    logic             r_line, r_busy, r_done;
    logic             w_tick, w_accept, w_line_nxt;

`ifdef SERIAL_BIT_TX_PARITY_EN
    logic r_par;
`endif

    assign o_ready  = (r_state == ST_IDLE);
    assign w_accept = i_valid && o_ready;
    assign o_line   = r_line;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

    // Held clear while idle so every frame starts its START bit at count 0.
    serial_bit_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (o_ready),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_START;
                    w_shift_nxt  = i_data;
                    w_bitcnt_nxt = '0;
                end
            end
            ST_START: if (w_tick) w_state_nxt = ST_DATA;
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bitcnt == LAST_BIT) begin
                        w_bitcnt_nxt = '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
                        w_state_nxt  = ST_PARITY;
`else
                        w_state_nxt  = ST_STOP;
`endif
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + BW'(1);
                    end
                end
            end
`ifdef SERIAL_BIT_TX_PARITY_EN
            ST_PARITY: if (w_tick) w_state_nxt = ST_STOP;
`endif
            ST_STOP: if (w_tick) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Line level is derived from the next state so o_line can be a flop.
    always_comb begin
        w_line_nxt = LINE_IDLE;
        case (w_state_nxt)
            ST_START:  w_line_nxt = LINE_START;
            ST_DATA:   w_line_nxt = w_shift_nxt[0];
`ifdef SERIAL_BIT_TX_PARITY_EN
            ST_PARITY: w_line_nxt = r_par;
`endif
            ST_STOP:   w_line_nxt = LINE_STOP;
            default:   w_line_nxt = LINE_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_line   <= LINE_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_line   <= w_line_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= (r_state == ST_STOP) && w_tick;
        end
    end

`ifdef SERIAL_BIT_TX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_par <= 1'b0;
        else if (w_accept)
            r_par <= ^i_data;
    end
`endif

endmodule

// File: tb/tb_serial_bit_tx.sv
// Scoreboard bench for serial_bit_tx: a frame model queues per-cycle expectations.
module tb_serial_bit_tx;

    localparam int W   = 10;
    localparam int CPB = 4;
`ifdef SERIAL_BIT_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic line;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, valid;
    logic [W-1:0] data;
    logic         ready, line, busy, done;

    logic         rst1, v1;
    logic [0:0]   d1;
    logic         ready1, line1, busy1, done1;

    serial_bit_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
        .o_ready(ready), .o_line(line), .o_busy(busy), .o_done(done)
    );

    serial_bit_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut_min (
        .i_clk(clk), .i_rst(rst1), .i_valid(v1), .i_data(d1),
        .o_ready(ready1), .o_line(line1), .o_busy(busy1), .o_done(done1)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    endtask

    // Reference model: one queue entry per clock cycle of expected outputs.
    exp_t q[$];
    bit   exp_ready = 1'b1;
    bit   mon_en = 1'b0;
    int   acc_cnt = 0;

    task automatic push_frame(input logic [W-1:0] w);
        logic fb[$];
        fb.push_back(1'b0);
        for (int i = 0; i < W; i++) fb.push_back(w[i]);
        if (PAR) fb.push_back(^w);
        fb.push_back(1'b1);
        foreach (fb[k])
            for (int c = 0; c < CPB; c++)
                q.push_back('{line: fb[k], busy: 1'b1, done: 1'b0, ready: 1'b0});
        q.push_back('{line: 1'b1, busy: 1'b0, done: 1'b1, ready: 1'b1});
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else if (valid && exp_ready) begin
            push_frame(data);
            acc_cnt++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (q.size() > 0) e = q.pop_front();
            else e = '{line: 1'b1, busy: 1'b0, done: 1'b0, ready: 1'b1};
            check("line", line, e.line);
            check("busy", busy, e.busy);
            check("done", done, e.done);
            check("ready", ready, e.ready);
            exp_ready = e.ready;
        end
    end

    task automatic send(input logic [W-1:0] w, input bit hold);
        int start;
        int t;
        start = acc_cnt;
        t = 0;
        valid = 1'b1;
        data  = w;
        while (acc_cnt == start && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (acc_cnt == start) begin
            n_chk++;
            $display("FAIL accept_timeout: word %h not accepted within 200 cycles", w);
        end
        if (!hold) valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL idle_timeout: %0d expected cycles still pending", q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid = 1'b1; data = 10'h155;
        rst1 = 1'b1; v1 = 1'b1; d1 = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; valid = 1'b0;
        rst1 = 1'b0; v1 = 1'b0;

        send(10'h2A5, 1'b0);
        wait_idle();

        send(10'h001, 1'b1);
        send(10'h3FF, 1'b0);
        wait_idle();

        // Reset lands during data bit 4 (cycles 21..24 after acceptance).
        send(10'h0F3, 1'b0);
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(10'h2C6, 1'b0);
        wait_idle();

        for (int n = 0; n < 30; n++) begin
            send(W'($urandom), 1'($urandom_range(0, 1)));
            if (!valid) repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end
        valid = 1'b0;
        wait_idle();

        // Minimum configuration: WIDTH=1, CLKS_PER_BIT=1, word 0.
        @(negedge clk);
        check("min_rst_line", line1, 1'b1);
        check("min_rst_ready", ready1, 1'b1);
        check("min_rst_busy", busy1, 1'b0);
        check("min_rst_done", done1, 1'b0);
        @(posedge clk); #1;
        v1 = 1'b1; d1 = 1'b0;
        @(posedge clk); #1;
        v1 = 1'b0;
        begin
            logic exp_l[$];
            exp_l = PAR ? '{1'b0, 1'b0, 1'b0, 1'b1} : '{1'b0, 1'b0, 1'b1};
            foreach (exp_l[k]) begin
                @(negedge clk);
                check("min_line", line1, exp_l[k]);
                check("min_busy", busy1, 1'b1);
                check("min_done", done1, 1'b0);
                if (k != exp_l.size() - 1) @(posedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            check("min_done_pulse", done1, 1'b1);
            check("min_done_line", line1, 1'b1);
            check("min_done_ready", ready1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
